// File: rtl/elastic_pipe_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : elastic_pipe_reg
// Purpose  : Elastic valid/ready register chain of STAGES slots carrying a
//            WIDTH-bit payload, with synchronous flush and occupancy count.
//            Optional one-entry skid ahead of slot 0 is enabled by defining
//            the macro ELASTIC_PIPE_SKID_EN; it makes in_ready a registered
//            signal with no combinational path from out_ready.
// Revision : 1.0 - initial release
// ============================================================================
module elastic_pipe_reg #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int CW     = $clog2(STAGES + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam int c_HEAD = STAGES - 1;

  // Slot state: index 0 faces the input, index c_HEAD drives the output.
  logic [STAGES-1:0] r_v;
  logic [WIDTH-1:0]  r_d [STAGES];
  logic [CW-1:0]     r_count;

  // Per-slot advance enable and the valid/data each slot would load.
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_up_v;
  logic [WIDTH-1:0]  w_up_d [STAGES];

  // Source feeding slot 0 (input directly, or the skid when occupied).
  logic              w_src_v;
  logic [WIDTH-1:0]  w_src_d;

  logic              w_in_fire;
  logic              w_out_fire;

  // A slot may advance when the head is being drained or any slot from it
  // to the head is empty; this is the unrolled form of the adv recurrence,
  // written without a self-referencing vector.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_adv
      assign w_adv[gi] = out_ready | ~(&r_v[STAGES-1:gi]);
    end
  endgenerate

  // Each slot loads from its predecessor; slot 0 loads from the source mux.
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_up
      if (gi == 0) begin : g_first
        assign w_up_v[gi] = w_src_v;
        assign w_up_d[gi] = w_src_d;
      end else begin : g_chain
        assign w_up_v[gi] = r_v[gi-1];
        assign w_up_d[gi] = r_d[gi-1];
      end
    end
  endgenerate

`ifdef ELASTIC_PIPE_SKID_EN
  logic             r_sv;
  logic [WIDTH-1:0] r_sd;

  // Ready comes straight from the skid flop, gated only by flush.
  assign in_ready  = ~r_sv & ~flush;
  assign w_in_fire = in_valid & in_ready;
  // An occupied skid is older than anything on the input, so it goes first.
  assign w_src_v   = r_sv | w_in_fire;
  assign w_src_d   = r_sv ? r_sd : in_data;

  // Skid captures an accepted payload only when slot 0 cannot take it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sv <= 1'b0;
      r_sd <= '0;
    end else if (flush) begin
      r_sv <= 1'b0;
    end else if (r_sv) begin
      if (w_adv[0]) begin
        r_sv <= 1'b0;
      end
    end else if (w_in_fire && !w_adv[0]) begin
      r_sv <= 1'b1;
      r_sd <= in_data;
    end
  end
`else
  // Without a skid, ready is the slot-0 advance, combinational from out_ready.
  assign in_ready  = w_adv[0] & ~flush;
  assign w_in_fire = in_valid & in_ready;
  assign w_src_v   = w_in_fire;
  assign w_src_d   = in_data;
`endif

  assign out_valid  = r_v[c_HEAD] & ~flush;
  assign out_data   = r_d[c_HEAD];
  assign w_out_fire = out_valid & out_ready;
  assign count      = r_count;

  // Slot chain: advancing slots take the upstream valid; data only moves
  // with a valid payload so bubbles never overwrite held data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_d[i] <= '0;
      end
    end else if (flush) begin
      r_v <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_adv[i]) begin
          r_v[i] <= w_up_v[i];
          if (w_up_v[i]) begin
            r_d[i] <= w_up_d[i];
          end
        end
      end
    end
  end

  // Occupancy: up on accept, down on delivery, cleared by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_in_fire && !w_out_fire) begin
      r_count <= r_count + CW'(1);
    end else if (!w_in_fire && w_out_fire) begin
      r_count <= r_count - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipe_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_elastic_pipe_reg
// Purpose  : Scoreboard bench for elastic_pipe_reg. Accepted payloads are
//            queued as expected outputs; a monitor pops and compares on each
//            delivery. Occupancy and ready are predicted from queue depth.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elastic_pipe_reg;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int CW     = $clog2(STAGES + 2);

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  elastic_pipe_reg #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               t;
    bit               exact;
  } item_t;

  item_t            q[$];
  int               n_vec      = 0;
  int               n_err      = 0;
  int               cyc        = 0;
  int               n_push     = 0;
  int               n_pop      = 0;
  int               n_drop     = 0;
  int               mc         = 0;
  bit               exact_mode = 0;
  bit               prev_stall = 0;
  logic [WIDTH-1:0] prev_data  = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Ready predicted from the model occupancy at the start of this cycle.
  function automatic logic exp_rdy(input int occ);
`ifdef ELASTIC_PIPE_SKID_EN
    return !flush && (occ <= STAGES);
`else
    return !flush && (out_ready || (occ < STAGES));
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    n_push     = 0;
    n_pop      = 0;
    n_drop     = 0;
    mc         = 0;
    prev_stall = 0;
  endtask

  // Occupancy snapshot and count comparison, just after each edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!reset) begin
      mc = n_push - n_pop - n_drop;
      chk("count", count, mc);
    end
  end

  // Input side: check ready, record accepted payloads, drop all on flush.
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", in_ready, exp_rdy(mc));
      if (flush) begin
        n_drop += q.size();
        q.delete();
      end else if (in_valid && in_ready) begin
        q.push_back('{d: in_data, t: cyc, exact: exact_mode});
        n_push++;
      end
    end
  end

  // Output side: compare deliveries, latency, stall stability, gating.
  always @(negedge clk) begin
    item_t it;
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (flush) chk("out_valid_flush", out_valid, 0);
      if (mc == 0) chk("out_valid_empty", out_valid, 0);
      if (prev_stall && !flush) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("out_extra_valid", out_valid, 0);
        end else begin
          it = q.pop_front();
          n_pop++;
          chk("out_data", out_data, it.d);
          if (it.exact) chk("latency", cyc - it.t, STAGES);
          else          chk("min_latency", (cyc - it.t) >= STAGES, 1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit ordy, input bit fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_count", count, 0);
    #2 reset = 1'b0;
    #1 chk("ready_after_reset", in_ready, 1);
    @(posedge clk);
    #2;

    // Streaming at full rate into an empty chain.
    exact_mode = 1;
    drive(1, 32'h11, 1, 0);
    drive(1, 32'h22, 1, 0);
    drive(1, 32'h33, 1, 0);
    repeat (4) drive(0, 32'h0, 1, 0);
    exact_mode = 0;

    // Back-pressure: third payload only fits with a skid.
    drive(1, 32'hA0, 0, 0);
    drive(1, 32'hA1, 0, 0);
    drive(1, 32'hA2, 0, 0);
    repeat (2) drive(0, 32'h0, 0, 0);
    repeat (5) drive(0, 32'h0, 1, 0);

    // Flush while full with a payload presented.
    drive(1, 32'hB0, 0, 0);
    drive(1, 32'hB1, 0, 0);
    drive(1, 32'hFF, 0, 1);
    drive(0, 32'h0, 0, 0);
    repeat (4) drive(0, 32'h0, 1, 0);

    // Simultaneous accept and deliver at full occupancy.
    drive(1, 32'hC0, 0, 0);
    drive(1, 32'hC1, 0, 0);
    exact_mode = 1;
    drive(1, 32'h55, 1, 0);
    exact_mode = 0;
    repeat (4) drive(0, 32'h0, 1, 0);

    // Asynchronous reset between edges with payloads held.
    drive(1, 32'hD0, 0, 0);
    drive(1, 32'hD1, 0, 0);
    #1 reset = 1'b1;
    model_reset();
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_data", out_data, 0);
    chk("midreset_count", count, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("ready_after_midreset", in_ready, 1);
    @(posedge clk);
    #2;
    exact_mode = 1;
    drive(1, 32'h77, 1, 0);
    repeat (4) drive(0, 32'h0, 1, 0);

    // Bubble between two payloads; gap data must never appear.
    drive(1, 32'h01, 1, 0);
    drive(0, 32'hDEAD_BEEF, 1, 0);
    drive(1, 32'h02, 1, 0);
    repeat (4) drive(0, 32'h0, 1, 0);
    exact_mode = 0;

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 63) == 0);
    end

    repeat (8) drive(0, 32'h0, 1, 0);
    chk("drain_pending", q.size(), 0);
    chk("drain_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/elastic_pipe_reg.md
# elastic_pipe_reg

Parametrised elastic pipeline register chain that supersedes the plain enable/clear flops between pipeline stages. It carries a WIDTH-bit payload through STAGES register slots using a valid/ready handshake on both sides. It supports a synchronous flush and reports an occupancy count. It sits between datapath stages wherever back-pressure must stall upstream without separate per-flop enable wiring.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- STAGES, 2, number of register slots in the chain (≥1)
- CW, $clog2(STAGES+2), occupancy counter width (derived; do not override)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous clear of all slots (and skid, if present)
- in_valid  in  1  upstream has a payload
- in_ready  out  1  block accepts the payload this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  payload available at the head slot
- out_ready  in  1  downstream accepts the payload this cycle
- out_data  out  WIDTH  head-slot payload
- count  out  CW  number of valid entries held (slots plus skid)

## Operation
- Slots 0..STAGES-1 each hold v[i] and d[i]. Slot 0 is the input side; slot STAGES-1 is the head.
- Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Slot advance: adv[STAGES-1] = out_ready | ~v[STAGES-1]; adv[i] = adv[i+1] | ~v[i].
- When adv[i] is true, slot i loads from slot i-1 (or from the input for i=0). Its v[i] takes the upstream valid.
- When adv[i] is false, slot i holds both data and valid.
- A data register loads only when its incoming valid is 1. Bubbles never overwrite data.
- out_valid = v[STAGES-1] & ~flush. out_data = d[STAGES-1].
- While out_valid=1 and out_ready=0, out_data must remain stable.
- in_ready is forced to 0 while flush=1.
- count: +1 on in_fire, −1 on out_fire, unchanged when both or neither occur. It never exceeds STAGES (or STAGES+1 with skid).
- Flush: at the next edge all v[i], the skid valid and count go to 0. Data registers are not required to clear. No handshake completes during a flush cycle.
- Reset: all v, all d, the skid and count go to 0 immediately. Outputs: out_valid=0, out_data=0, count=0. in_ready=1 once reset deasserts.
- Reset mid-transfer discards all held payloads. No partial-state recovery.

## Timing
- Latency is STAGES cycles with no stall: a payload accepted at edge t appears on out_valid/out_data after edge t+STAGES−1 and is visible in cycle t+STAGES.
- Throughput is 1 payload per cycle with out_ready held at 1.
- Without skid, in_ready is combinational from out_ready through the adv chain.
- out_valid and out_data are registered outputs, except for the combinational flush gating on out_valid.
- Full condition: all slots valid and out_ready=0. Then in_ready=0 (no skid) or the skid absorbs one payload (skid build).
- Empty condition: count=0 and out_valid=0. in_ready=1 unless flush=1.

## Configuration
- Macro: ELASTIC_PIPE_SKID_EN.
- **Defined:**
  - A one-entry skid register (sv, sd) is added ahead of slot 0.
  - in_ready = ~sv & ~flush, taken directly from a flop. There is no combinational path from out_ready.
  - If adv[0]=1 and sv=0, input bypasses the skid straight into slot 0, so latency is unchanged.
  - If adv[0]=0 on in_fire, the payload goes to the skid.
  - While sv=1, slot 0 loads from the skid when adv[0]=1.
  - Ordering is strictly FIFO. Maximum count is STAGES+1.
- **Undefined:** no skid; in_ready behaves as described under Timing; maximum count is STAGES.

## Test plan
- Streaming, WIDTH=32, STAGES=2, out_ready=1: send 0x11, 0x22, 0x33 on consecutive cycles. Required response: out_data shows 0x11, 0x22, 0x33 on consecutive cycles, the first appearing 2 cycles after its accept, with count stable at 2 mid-stream.
- Back-pressure: out_ready=0 while sending 0xA0, 0xA1, 0xA2.
  - Without skid: only 0xA0 and 0xA1 are accepted, in_ready drops to 0, and count=2.
  - With skid: 0xA2 is also accepted, then in_ready=0 and count=3.
  - Release out_ready=1. Required response: outputs in order 0xA0, 0xA1, (0xA2), with out_data stable during the stall.
- Flush: fill to count=2, then assert flush for 1 cycle with in_valid=1 and data 0xFF. Required response: in_ready=0 and out_valid=0 during the flush cycle; count=0 next cycle; 0xFF is never output.
- Simultaneous in/out at full: with count=2 and out_ready=1, send 0x55. Required response: count stays 2 and 0x55 emerges 2 cycles later.
- Async reset mid-stream: assert reset between edges with count=2. Required response: out_valid=0, out_data=0 and count=0 immediately. After deassert, in_ready=1 and the first new payload 0x77 appears at the output with latency 2.
- Bubbles: in_valid alternating 1/0 with data 0x01, X, 0x02. Required response: outputs 0x01 and 0x02 only, never X, with out_valid=0 in the gap cycle.
